// File: rtl/layer_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : layer_sequencer_if
// Brief    : Control/status bundle between the layer sequencer and its engines.
// Revision : 1.0 - initial release
// ============================================================================
interface layer_sequencer_if;
    logic       start;
    logic       conv_done;
    logic       pool_done;
    logic       c_load;
    logic       conv;
    logic       pool;
    logic       first_write;
    logic [3:0] out_c;
    logic [2:0] in_c;
    logic       busy;
    logic       done;

    modport master (
        input  start, conv_done, pool_done,
        output c_load, conv, pool, first_write, out_c, in_c, busy, done
    );

    modport slave (
        output start, conv_done, pool_done,
        input  c_load, conv, pool, first_write, out_c, in_c, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : layer_sequencer
// Brief    : Walks (out_c, in_c) over a conv layer, pulsing load/conv/pool/done.
//            Define LAYER_SEQ_POOL_EN to include the pooling stage per out_c.
// Revision : 1.0 - initial release
// ============================================================================
module layer_sequencer #(
    parameter int OC = 15,
    parameter int IC = 7
) (
    input  wire logic           clk,
    input  wire logic           rst,
    layer_sequencer_if.master   bus
);

    localparam logic [3:0] c_IDLE      = 4'd0;
    localparam logic [3:0] c_LOAD      = 4'd1;
    localparam logic [3:0] c_CONV      = 4'd2;
    localparam logic [3:0] c_WAIT_CONV = 4'd3;
    localparam logic [3:0] c_NEXT_CIN  = 4'd4;
`ifdef LAYER_SEQ_POOL_EN
    localparam logic [3:0] c_POOL      = 4'd5;
    localparam logic [3:0] c_WAIT_POOL = 4'd6;
`endif
    localparam logic [3:0] c_NEXT_COUT = 4'd7;
    localparam logic [3:0] c_FINISH    = 4'd8;

    localparam logic [3:0] c_OC = 4'(OC);
    localparam logic [2:0] c_IC = 3'(IC);

    // Where the last input-channel pass of an output channel leads.
`ifdef LAYER_SEQ_POOL_EN
    localparam logic [3:0] c_AFTER_LAST_CIN = c_POOL;
`else
    localparam logic [3:0] c_AFTER_LAST_CIN = c_NEXT_COUT;
`endif

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic [3:0] r_out_c;
    logic [2:0] r_in_c;
    logic       r_c_load;
    logic       r_conv;
    logic       r_done;
    logic       r_busy;

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:      if (bus.start) w_next = c_LOAD;
            c_LOAD:      w_next = c_CONV;
            c_CONV:      w_next = c_WAIT_CONV;
            c_WAIT_CONV: begin
                if (bus.conv_done) begin
                    w_next = (r_in_c < c_IC) ? c_NEXT_CIN : c_AFTER_LAST_CIN;
                end
            end
            c_NEXT_CIN:  w_next = c_LOAD;
`ifdef LAYER_SEQ_POOL_EN
            c_POOL:      w_next = c_WAIT_POOL;
            c_WAIT_POOL: if (bus.pool_done) w_next = c_NEXT_COUT;
`endif
            c_NEXT_COUT: w_next = (r_out_c < c_OC) ? c_LOAD : c_FINISH;
            c_FINISH:    w_next = c_IDLE;
            default:     w_next = c_IDLE;
        endcase
    end

    // Pulses are registered from the next state so they line up with the
    // cycle spent in the matching state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_out_c  <= '0;
            r_in_c   <= '0;
            r_c_load <= 1'b0;
            r_conv   <= 1'b0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_c_load <= (w_next == c_LOAD);
            r_conv   <= (w_next == c_CONV);
            r_done   <= (w_next == c_FINISH);
            r_busy   <= (w_next != c_IDLE);
            case (r_state)
                c_IDLE: begin
                    if (bus.start) begin
                        r_out_c <= '0;
                        r_in_c  <= '0;
                    end
                end
                c_NEXT_CIN: r_in_c <= r_in_c + 3'd1;
                c_NEXT_COUT: begin
                    if (r_out_c < c_OC) begin
                        r_out_c <= r_out_c + 4'd1;
                        r_in_c  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef LAYER_SEQ_POOL_EN
    logic r_pool;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pool <= 1'b0;
        end else begin
            r_pool <= (w_next == c_POOL);
        end
    end

    assign bus.pool = r_pool;
`else
    logic w_unused_pool_done;
    assign w_unused_pool_done = bus.pool_done;
    assign bus.pool           = 1'b0;
`endif

    assign bus.c_load      = r_c_load;
    assign bus.conv        = r_conv;
    assign bus.done        = r_done;
    assign bus.busy        = r_busy;
    assign bus.out_c       = r_out_c;
    assign bus.in_c        = r_in_c;
    assign bus.first_write = (r_in_c == 3'd0);

endmodule
`default_nettype wire

// File: tb/tb_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_layer_sequencer
// Brief    : Scoreboard bench for layer_sequencer (OC=1, IC=1), both pool builds.
// Revision : 1.0 - initial release
// ============================================================================
module tb_layer_sequencer;

    localparam int c_K_LOAD = 0;
    localparam int c_K_CONV = 1;
    localparam int c_K_POOL = 2;
    localparam int c_K_DONE = 3;

    typedef struct {
        int kind;
        int oc;
        int ic;
        int gap;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    logic cd_resp   = 1'b0;
    logic cd_manual = 1'b0;
    logic pd_resp   = 1'b0;
    logic pd_manual = 1'b0;
    logic hold_conv = 1'b0;
    logic hold_pool = 1'b0;
    int   dc = 0;
    int   dp = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   last_cyc = 0;
    logic [3:0] prev_p = 4'd0;
    ev_t  exp_q[$];

    layer_sequencer_if bus ();

    assign bus.conv_done = cd_resp | cd_manual;
    assign bus.pool_done = pd_resp | pd_manual;

    layer_sequencer #(.OC(1), .IC(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            c_K_LOAD: return "c_load";
            c_K_CONV: return "conv";
            c_K_POOL: return "pool";
            default:  return "done";
        endcase
    endfunction

    // Monitor: every pulse must match the head of the expected queue.
    always @(negedge clk) begin
        logic [3:0] p;
        ev_t        e;
        int         k;
        int         gap;
        logic       bad;
        p = {bus.done, bus.pool, bus.conv, bus.c_load};
        if (!rst && p != 4'd0) begin
            k = bus.c_load ? c_K_LOAD : bus.conv ? c_K_CONV : bus.pool ? c_K_POOL : c_K_DONE;
            gap = cyc - last_cyc;
            last_cyc = cyc;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL event: got %s(%0d,%0d) pulses=%b, expected no pulse",
                         kname(k), bus.out_c, bus.in_c, p);
            end else begin
                e = exp_q.pop_front();
                bad = (k != e.kind) || (int'(bus.out_c) != e.oc) || (int'(bus.in_c) != e.ic) ||
                      (bus.first_write != (e.ic == 0)) || (e.gap >= 0 && gap != e.gap) ||
                      ($countones(p) != 1) || ((p & prev_p) != 4'd0);
                if (bad) begin
                    miscompares++;
                    $display("FAIL event: got %s(%0d,%0d) fw=%0d gap=%0d pulses=%b prev=%b, expected %s(%0d,%0d) fw=%0d gap=%0d one-hot",
                             kname(k), bus.out_c, bus.in_c, bus.first_write, gap, p, prev_p,
                             kname(e.kind), e.oc, e.ic, (e.ic == 0), e.gap);
                end
            end
        end
        prev_p = rst ? 4'd0 : p;
    end

    // Conv engine model: answer each conv pulse after dc extra cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.conv && !hold_conv) begin
                repeat (dc + 1) @(negedge clk);
                cd_resp = 1'b1;
                @(negedge clk);
                cd_resp = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.pool && !hold_pool) begin
                repeat (dp + 1) @(negedge clk);
                pd_resp = 1'b1;
                @(negedge clk);
                pd_resp = 1'b0;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_ev(input int k, input int oc, input int ic, input int gap);
        ev_t e;
        e.kind = k;
        e.oc   = oc;
        e.ic   = ic;
        e.gap  = gap;
        exp_q.push_back(e);
    endtask

    // Full OC=1/IC=1 layer; gaps are cycles since the previous pulse.
    task automatic push_layer(input int d_c, input int d_p);
`ifdef LAYER_SEQ_POOL_EN
        push_ev(c_K_LOAD, 0, 0, -1);
        push_ev(c_K_CONV, 0, 0, 1);
        push_ev(c_K_LOAD, 0, 1, 3 + d_c);
        push_ev(c_K_CONV, 0, 1, 1);
        push_ev(c_K_POOL, 0, 1, 2 + d_c);
        push_ev(c_K_LOAD, 1, 0, 3 + d_p);
        push_ev(c_K_CONV, 1, 0, 1);
        push_ev(c_K_LOAD, 1, 1, 3 + d_c);
        push_ev(c_K_CONV, 1, 1, 1);
        push_ev(c_K_POOL, 1, 1, 2 + d_c);
        push_ev(c_K_DONE, 1, 1, 3 + d_p);
`else
        push_ev(c_K_LOAD, 0, 0, -1);
        push_ev(c_K_CONV, 0, 0, 1);
        push_ev(c_K_LOAD, 0, 1, 3 + d_c);
        push_ev(c_K_CONV, 0, 1, 1);
        push_ev(c_K_LOAD, 1, 0, 3 + d_c);
        push_ev(c_K_CONV, 1, 0, 1);
        push_ev(c_K_LOAD, 1, 1, 3 + d_c);
        push_ev(c_K_CONV, 1, 1, 1);
        push_ev(c_K_DONE, 1, 1, 3 + d_c);
`endif
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic drain(input string name);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < 2000) begin
            @(negedge clk);
            i++;
        end
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic check_idle_outputs(input string tag, input int oc, input int ic);
        check({tag, "_busy"},  int'(bus.busy), 0);
        check({tag, "_out_c"}, int'(bus.out_c), oc);
        check({tag, "_in_c"},  int'(bus.in_c), ic);
        check({tag, "_fw"},    int'(bus.first_write), (ic == 0) ? 1 : 0);
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_c_load", int'(bus.c_load), 0);
        check("rst_conv",   int'(bus.conv), 0);
        check("rst_pool",   int'(bus.pool), 0);
        check("rst_done",   int'(bus.done), 0);
        check_idle_outputs("rst", 0, 0);
        rst = 1'b0;

        // Fastest engines: 4-cycle passes.
        dc = 0;
        dp = 0;
        push_layer(0, 0);
        pulse_start();
        drain("run1_drain");
        @(negedge clk);
        check_idle_outputs("run1_end", 1, 1);

        // Long conv stall, with a stray start while busy.
        dc = 50;
        dp = 2;
        push_layer(50, 2);
        pulse_start();
        repeat (20) @(negedge clk);
        check("stall_busy", int'(bus.busy), 1);
        pulse_start();
        drain("run2_drain");
        @(negedge clk);
        check_idle_outputs("run2_end", 1, 1);

        // Engine completions while idle must be ignored.
        @(negedge clk);
        cd_manual = 1'b1;
        pd_manual = 1'b1;
        @(negedge clk);
        cd_manual = 1'b0;
        pd_manual = 1'b0;
        repeat (5) @(negedge clk);
        check_idle_outputs("idle_done_ignored", 1, 1);

        // Reset while parked waiting on an engine, colliding with start/done inputs.
        dc = 0;
        dp = 0;
`ifdef LAYER_SEQ_POOL_EN
        hold_pool = 1'b1;
        push_ev(c_K_LOAD, 0, 0, -1);
        push_ev(c_K_CONV, 0, 0, 1);
        push_ev(c_K_LOAD, 0, 1, 3);
        push_ev(c_K_CONV, 0, 1, 1);
        push_ev(c_K_POOL, 0, 1, 2);
`else
        hold_conv = 1'b1;
        push_ev(c_K_LOAD, 0, 0, -1);
        push_ev(c_K_CONV, 0, 0, 1);
`endif
        pulse_start();
        drain("park_drain");
        repeat (3) @(negedge clk);
        check("park_busy", int'(bus.busy), 1);
        rst       = 1'b1;
        bus.start = 1'b1;
        cd_manual = 1'b1;
        pd_manual = 1'b1;
        @(negedge clk);
        check("midrst_c_load", int'(bus.c_load), 0);
        check("midrst_conv",   int'(bus.conv), 0);
        check("midrst_pool",   int'(bus.pool), 0);
        check("midrst_done",   int'(bus.done), 0);
        check_idle_outputs("midrst", 0, 0);
        rst       = 1'b0;
        bus.start = 1'b0;
        cd_manual = 1'b0;
        pd_manual = 1'b0;
        hold_conv = 1'b0;
        hold_pool = 1'b0;
        @(negedge clk);
        check("post_rst_busy", int'(bus.busy), 0);

        // Restart from (0,0) after the reset.
        dc = 1;
        dp = 1;
        push_layer(1, 1);
        pulse_start();
        drain("run3_drain");
        @(negedge clk);
        check_idle_outputs("run3_end", 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
